// File: rtl/text_overlay_sched_pkg.sv
// Shared types and constants for the text overlay scheduler.
//   slot_hdr_t      : per-slot header (origin, length, scale, enable)
//   commit_state_t  : shadow-to-active commit FSM states
//   eff_scale()     : maps a stored scale of 0 to 1
package text_overlay_pkg;

  localparam int CHAR_W       = 8;
  localparam int CHAR_H       = 8;
  localparam int CHAR_SPACING = 1;
  localparam int CHAR_PITCH   = CHAR_W + CHAR_SPACING;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef struct packed {
    logic        enable;
    logic [1:0]  scale;
    logic [4:0]  len;
    logic [9:0]  pos_y;
    logic [10:0] pos_x;
  } slot_hdr_t;

  localparam slot_hdr_t HDR_RESET = '{enable: 1'b0, scale: 2'd1, len: 5'd0,
                                      pos_y: 10'd0, pos_x: 11'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_COPY
  } commit_state_t;

  function automatic logic [1:0] eff_scale(input logic [1:0] scale);
    return (scale == 2'd0) ? 2'd1 : scale;
  endfunction

endpackage

// File: rtl/text_overlay_sched_if.sv
// Configuration bus for the text overlay scheduler.
//   master : host side (drives writes and commit requests)
//   slave  : scheduler side (returns cfg_ready and commit_busy)
interface text_overlay_sched_if #(
  parameter int NUM_SLOTS = 4
) ();
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic                         cfg_type;
  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot;
  logic [3:0]                   cfg_idx;
  logic [31:0]                  cfg_data;
  logic                         cfg_commit;
  logic                         commit_busy;

  modport master (
    output cfg_valid, cfg_type, cfg_slot, cfg_idx, cfg_data, cfg_commit,
    input  cfg_ready, commit_busy
  );

  modport slave (
    input  cfg_valid, cfg_type, cfg_slot, cfg_idx, cfg_data, cfg_commit,
    output cfg_ready, commit_busy
  );
endinterface

// File: rtl/text_overlay_sched_slot_hit.sv
// Combinational box test for one string slot.
//   hdr            : active header of the slot
//   curr_x, curr_y : pixel coordinate
//   hit            : pixel lies inside the enabled slot's text box
//   rel_x          : pixel x relative to the slot origin
module text_slot_hit
  import text_overlay_pkg::*;
(
  input  slot_hdr_t   hdr,
  input  logic [10:0] curr_x,
  input  logic [9:0]  curr_y,
  output logic        hit,
  output logic [10:0] rel_x
);
  logic [1:0]  es;
  logic [11:0] dx, dy, len9, box_w, box_h;

  assign es = eff_scale(hdr.scale);

  // 12-bit differences: bit 11 is the borrow, set when the pixel is left of / above the origin
  assign dx   = {1'b0, curr_x} - {1'b0, hdr.pos_x};
  assign dy   = {2'b0, curr_y} - {2'b0, hdr.pos_y};
  assign len9 = 12'(hdr.len) * 12'(CHAR_PITCH);

  always_comb begin
    case (es)
      2'd2:    box_w = len9 << 1;
      2'd3:    box_w = len9 + (len9 << 1);
      default: box_w = len9;
    endcase
  end

  assign box_h = 12'(CHAR_H) * 12'(es);

  assign hit = hdr.enable && (hdr.len != 5'd0) && !dx[11] && !dy[11]
               && (dx < box_w) && (dy < box_h);
  assign rel_x = dx[10:0];
endmodule

// File: rtl/text_overlay_sched.sv
// Text overlay scheduler: picks the owning string slot and character cell per
// pixel and feeds one shared glyph renderer. Slot contents are written into
// shadow storage and copied to active storage only at frame start.
//   clk, rst_n          : pixel clock, async active-low reset
//   frame_start         : start-of-vblank pulse, triggers a pending commit
//   cfg                 : configuration bus (slave modport)
//   pix_valid, curr_x/y : pixel coordinate in
//   out_*               : coordinate delayed 2 cycles
//   slot_hit, slot_id   : winning slot for the pixel
//   char_code/pos/scale : glyph renderer drive
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | accepting config writes
// ST_PENDING | commit requested, waiting for frame_start
// ST_COPY    | one cycle: active <= shadow
module text_overlay_sched
  import text_overlay_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int MAX_CHARS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  text_overlay_sched_if.slave          cfg,
  input  logic                         pix_valid,
  input  logic [10:0]                  curr_x,
  input  logic [9:0]                   curr_y,
  output logic                         out_valid,
  output logic [10:0]                  out_x,
  output logic [9:0]                   out_y,
  output logic                         slot_hit,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_id,
  output logic [7:0]                   char_code,
  output logic [10:0]                  char_pos_x,
  output logic [9:0]                   char_pos_y,
  output logic [1:0]                   char_scale
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  slot_hdr_t     sh_hdr  [NUM_SLOTS];
  slot_hdr_t     act_hdr [NUM_SLOTS];
  logic [7:0]    sh_chr  [NUM_SLOTS][MAX_CHARS];
  logic [7:0]    act_chr [NUM_SLOTS][MAX_CHARS];
  commit_state_t state;

  logic       cfg_fire;
  logic [4:0] len_clamped;
  logic       unused_cfg;

  assign cfg_fire    = cfg.cfg_valid & cfg.cfg_ready;
  assign len_clamped = (cfg.cfg_data[25:21] > 5'd16) ? 5'd16 : cfg.cfg_data[25:21];
  assign unused_cfg  = &{1'b0, cfg.cfg_data[31:29]};

  // Config writes and commit FSM share one block since COPY reads the shadow
  // the same edge a write could land; a write in COPY is impossible (ready=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cfg.cfg_ready   <= 1'b1;
      cfg.commit_busy <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        sh_hdr[s]  <= HDR_RESET;
        act_hdr[s] <= HDR_RESET;
        for (int c = 0; c < MAX_CHARS; c++) begin
          sh_chr[s][c]  <= SPACE_CHAR;
          act_chr[s][c] <= SPACE_CHAR;
        end
      end
    end else begin
      // Slot indices beyond NUM_SLOTS match no entry and are dropped
      if (cfg_fire) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (cfg.cfg_slot == SLOT_W'(s)) begin
            if (cfg.cfg_type) begin
              sh_hdr[s] <= '{enable: cfg.cfg_data[28], scale: cfg.cfg_data[27:26],
                             len: len_clamped, pos_y: cfg.cfg_data[20:11],
                             pos_x: cfg.cfg_data[10:0]};
            end else begin
              for (int c = 0; c < MAX_CHARS; c++) begin
                if (cfg.cfg_idx == 4'(c)) sh_chr[s][c] <= cfg.cfg_data[7:0];
              end
            end
          end
        end
      end
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_commit) begin
            state           <= ST_PENDING;
            cfg.cfg_ready   <= 1'b0;
            cfg.commit_busy <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (frame_start) state <= ST_COPY;
        end
        ST_COPY: begin
          for (int s = 0; s < NUM_SLOTS; s++) begin
            act_hdr[s] <= sh_hdr[s];
            for (int c = 0; c < MAX_CHARS; c++) act_chr[s][c] <= sh_chr[s][c];
          end
          state           <= ST_IDLE;
          cfg.cfg_ready   <= 1'b1;
          cfg.commit_busy <= 1'b0;
        end
        default: begin
          state           <= ST_IDLE;
          cfg.cfg_ready   <= 1'b1;
          cfg.commit_busy <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: per-slot box test and priority select
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [10:0]          rel_x_vec [NUM_SLOTS];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    text_slot_hit u_hit (
      .hdr    (act_hdr[g]),
      .curr_x (curr_x),
      .curr_y (curr_y),
      .hit    (hit_vec[g]),
      .rel_x  (rel_x_vec[g])
    );
  end

  logic              win_hit;
  logic [SLOT_W-1:0] win_slot;
  logic [10:0]       win_rel, win_px;
  logic [9:0]        win_py;
  logic [1:0]        win_es;

  // Walk downward so the lowest-index hitting slot is the last assignment
  always_comb begin
    win_hit  = 1'b0;
    win_slot = '0;
    win_rel  = '0;
    win_px   = '0;
    win_py   = '0;
    win_es   = 2'd1;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (pix_valid && hit_vec[s]) begin
        win_hit  = 1'b1;
        win_slot = SLOT_W'(s);
        win_rel  = rel_x_vec[s];
        win_px   = act_hdr[s].pos_x;
        win_py   = act_hdr[s].pos_y;
        win_es   = eff_scale(act_hdr[s].scale);
      end
    end
  end

  logic              s1_valid, s1_hit;
  logic [10:0]       s1_x, s1_rel, s1_px;
  logic [9:0]        s1_y, s1_py;
  logic [SLOT_W-1:0] s1_slot;
  logic [1:0]        s1_es;

  // Stage 2: cell index via constant divide selected by scale
  logic [3:0]  char_idx;
  logic [10:0] cell_off;

  always_comb begin
    case (s1_es)
      2'd2: begin
        char_idx = 4'(s1_rel / 11'd18);
        cell_off = 11'(char_idx) * 11'd18;
      end
      2'd3: begin
        char_idx = 4'(s1_rel / 11'd27);
        cell_off = 11'(char_idx) * 11'd27;
      end
      default: begin
        char_idx = 4'(s1_rel / 11'd9);
        cell_off = 11'(char_idx) * 11'd9;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_hit     <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_rel     <= '0;
      s1_px      <= '0;
      s1_py      <= '0;
      s1_slot    <= '0;
      s1_es      <= 2'd1;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      slot_hit   <= 1'b0;
      slot_id    <= '0;
      char_code  <= SPACE_CHAR;
      char_pos_x <= '0;
      char_pos_y <= '0;
      char_scale <= 2'd1;
    end else begin
      s1_valid   <= pix_valid;
      s1_hit     <= win_hit;
      s1_x       <= curr_x;
      s1_y       <= curr_y;
      s1_rel     <= win_rel;
      s1_px      <= win_px;
      s1_py      <= win_py;
      s1_slot    <= win_slot;
      s1_es      <= win_es;
      out_valid  <= s1_valid;
      out_x      <= s1_x;
      out_y      <= s1_y;
      slot_hit   <= s1_hit;
      slot_id    <= s1_hit ? s1_slot : '0;
      char_code  <= s1_hit ? act_chr[s1_slot][char_idx] : SPACE_CHAR;
      char_pos_x <= s1_hit ? (s1_px + cell_off) : 11'd0;
      char_pos_y <= s1_hit ? s1_py : 10'd0;
      char_scale <= s1_es;
    end
  end
endmodule

// File: tb/tb_text_overlay_sched.sv
// Directed bench for text_overlay_sched: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_text_overlay_sched;
  import text_overlay_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [10:0] curr_x = '0;
  logic [9:0]  curr_y = '0;
  logic        out_valid;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        slot_hit;
  logic [1:0]  slot_id;
  logic [7:0]  char_code;
  logic [10:0] char_pos_x;
  logic [9:0]  char_pos_y;
  logic [1:0]  char_scale;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_overlay_sched_if #(.NUM_SLOTS(4)) cfg_if ();

  text_overlay_sched #(.NUM_SLOTS(4), .MAX_CHARS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .cfg        (cfg_if),
    .pix_valid  (pix_valid),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .out_valid  (out_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .slot_hit   (slot_hit),
    .slot_id    (slot_id),
    .char_code  (char_code),
    .char_pos_x (char_pos_x),
    .char_pos_y (char_pos_y),
    .char_scale (char_scale)
  );

  function automatic logic [31:0] hdr_word(input logic [10:0] x, input logic [9:0] y,
                                           input logic [4:0] len, input logic [1:0] sc,
                                           input logic en);
    return {3'b000, en, sc, len, y, x};
  endfunction

  task automatic cfg_write(input logic typ, input logic [1:0] slot, input logic [3:0] idx,
                           input logic [31:0] data);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_type  = typ;
    cfg_if.cfg_slot  = slot;
    cfg_if.cfg_idx   = idx;
    cfg_if.cfg_data  = data;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wr_hdr(input logic [1:0] slot, input logic [31:0] w);
    cfg_write(1'b1, slot, 4'd0, w);
  endtask

  task automatic wr_chr(input logic [1:0] slot, input logic [3:0] idx, input logic [7:0] ch);
    cfg_write(1'b0, slot, idx, {24'd0, ch});
  endtask

  task automatic commit_frame();
    @(negedge clk);
    cfg_if.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_if.cfg_commit = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  // Returns with the outputs for this pixel visible (2-cycle latency)
  task automatic pixel(input logic [10:0] x, input logic [9:0] y);
    @(negedge clk);
    pix_valid = 1'b1;
    curr_x    = x;
    curr_y    = y;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_type   = 1'b0;
    cfg_if.cfg_slot   = '0;
    cfg_if.cfg_idx    = '0;
    cfg_if.cfg_data   = '0;
    cfg_if.cfg_commit = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cfg_if.cfg_ready); end
    checks++; if (cfg_if.commit_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", cfg_if.commit_busy); end
    checks++; if (out_valid !== 1'b0 || slot_hit !== 1'b0 || out_x !== 11'd0 || char_pos_x !== 11'd0)
      begin errors++; $display("FAIL rst_pipe: valid=%b hit=%b x=%0d cpx=%0d want all 0", out_valid, slot_hit, out_x, char_pos_x); end
    checks++; if (char_code !== 8'h20) begin errors++; $display("FAIL rst_char: got %h want 20", char_code); end
    checks++; if (char_scale !== 2'd1) begin errors++; $display("FAIL rst_scale: got %0d want 1", char_scale); end
  endtask

  task automatic test_basic();
    wr_hdr(2'd0, hdr_word(11'd100, 10'd50, 5'd3, 2'd2, 1'b1));
    wr_chr(2'd0, 4'd0, 8'h41);
    wr_chr(2'd0, 4'd1, 8'h42);
    wr_chr(2'd0, 4'd2, 8'h43);
    pixel(11'd118, 10'd50);
    checks++; if (slot_hit !== 1'b0) begin errors++; $display("FAIL basic_shadow_only: got hit=%b want 0", slot_hit); end
    @(negedge clk);
    cfg_if.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_if.cfg_commit = 1'b0;
    checks++; if (cfg_if.commit_busy !== 1'b1 || cfg_if.cfg_ready !== 1'b0)
      begin errors++; $display("FAIL basic_pending: busy=%b ready=%b want 1 0", cfg_if.commit_busy, cfg_if.cfg_ready); end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++; if (cfg_if.commit_busy !== 1'b1) begin errors++; $display("FAIL basic_copy_busy: got %b want 1", cfg_if.commit_busy); end
    @(negedge clk);
    checks++; if (cfg_if.commit_busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1)
      begin errors++; $display("FAIL basic_idle: busy=%b ready=%b want 0 1", cfg_if.commit_busy, cfg_if.cfg_ready); end
    pixel(11'd118, 10'd50);
    checks++; if (out_valid !== 1'b1 || out_x !== 11'd118 || out_y !== 10'd50)
      begin errors++; $display("FAIL basic_coord: v=%b x=%0d y=%0d want 1 118 50", out_valid, out_x, out_y); end
    checks++; if (slot_hit !== 1'b1 || slot_id !== 2'd0) begin errors++; $display("FAIL basic_hit: hit=%b id=%0d want 1 0", slot_hit, slot_id); end
    checks++; if (char_code !== 8'h42) begin errors++; $display("FAIL basic_char: got %h want 42", char_code); end
    checks++; if (char_pos_x !== 11'd118 || char_pos_y !== 10'd50)
      begin errors++; $display("FAIL basic_pos: got %0d,%0d want 118,50", char_pos_x, char_pos_y); end
    checks++; if (char_scale !== 2'd2) begin errors++; $display("FAIL basic_scale: got %0d want 2", char_scale); end
  endtask

  task automatic test_overlap();
    wr_hdr(2'd1, hdr_word(11'd190, 10'd95, 5'd4, 2'd1, 1'b1));
    wr_chr(2'd1, 4'd1, 8'h5A);
    wr_hdr(2'd0, hdr_word(11'd200, 10'd100, 5'd2, 2'd1, 1'b1));
    commit_frame();
    pixel(11'd200, 10'd100);
    checks++; if (slot_hit !== 1'b1 || slot_id !== 2'd0 || char_code !== 8'h41 || char_pos_x !== 11'd200)
      begin errors++; $display("FAIL overlap_prio: hit=%b id=%0d ch=%h px=%0d want 1 0 41 200", slot_hit, slot_id, char_code, char_pos_x); end
    wr_hdr(2'd0, hdr_word(11'd200, 10'd100, 5'd2, 2'd1, 1'b0));
    commit_frame();
    pixel(11'd200, 10'd100);
    checks++; if (slot_hit !== 1'b1 || slot_id !== 2'd1 || char_code !== 8'h5A)
      begin errors++; $display("FAIL overlap_slot1: hit=%b id=%0d ch=%h want 1 1 5a", slot_hit, slot_id, char_code); end
    checks++; if (char_pos_x !== 11'd199 || char_pos_y !== 10'd95)
      begin errors++; $display("FAIL overlap_pos: got %0d,%0d want 199,95", char_pos_x, char_pos_y); end
  endtask

  task automatic test_boundaries();
    wr_hdr(2'd2, hdr_word(11'd10, 10'd300, 5'd3, 2'd1, 1'b1));
    wr_chr(2'd2, 4'd0, 8'h58);
    wr_chr(2'd2, 4'd2, 8'h71);
    wr_hdr(2'd3, hdr_word(11'd0, 10'd400, 5'd31, 2'd1, 1'b1));
    commit_frame();
    pixel(11'd9, 10'd300);
    checks++; if (slot_hit !== 1'b0 || char_code !== 8'h20 || char_pos_x !== 11'd0)
      begin errors++; $display("FAIL bnd_left: hit=%b ch=%h px=%0d want 0 20 0", slot_hit, char_code, char_pos_x); end
    pixel(11'd36, 10'd300);
    checks++; if (slot_hit !== 1'b1 || slot_id !== 2'd2 || char_code !== 8'h71 || char_pos_x !== 11'd28)
      begin errors++; $display("FAIL bnd_last: hit=%b id=%0d ch=%h px=%0d want 1 2 71 28", slot_hit, slot_id, char_code, char_pos_x); end
    pixel(11'd37, 10'd300);
    checks++; if (slot_hit !== 1'b0) begin errors++; $display("FAIL bnd_right: got hit=%b want 0", slot_hit); end
    pixel(11'd10, 10'd307);
    checks++; if (slot_hit !== 1'b1 || char_code !== 8'h58) begin errors++; $display("FAIL bnd_lastrow: hit=%b ch=%h want 1 58", slot_hit, char_code); end
    pixel(11'd10, 10'd308);
    checks++; if (slot_hit !== 1'b0) begin errors++; $display("FAIL bnd_bottom: got hit=%b want 0", slot_hit); end
    pixel(11'd143, 10'd400);
    checks++; if (slot_hit !== 1'b1 || slot_id !== 2'd3 || char_pos_x !== 11'd135 || char_code !== 8'h20)
      begin errors++; $display("FAIL bnd_clamp_in: hit=%b id=%0d px=%0d ch=%h want 1 3 135 20", slot_hit, slot_id, char_pos_x, char_code); end
    pixel(11'd144, 10'd400);
    checks++; if (slot_hit !== 1'b0) begin errors++; $display("FAIL bnd_clamp_out: got hit=%b want 0", slot_hit); end
    wr_hdr(2'd2, hdr_word(11'd10, 10'd300, 5'd3, 2'd0, 1'b1));
    commit_frame();
    pixel(11'd36, 10'd300);
    checks++; if (slot_hit !== 1'b1 || char_scale !== 2'd1 || char_code !== 8'h71)
      begin errors++; $display("FAIL bnd_scale0: hit=%b sc=%0d ch=%h want 1 1 71", slot_hit, char_scale, char_code); end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    cfg_if.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_if.cfg_commit = 1'b0;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_type   = 1'b0;
    cfg_if.cfg_slot   = 2'd2;
    cfg_if.cfg_idx    = 4'd0;
    cfg_if.cfg_data   = 32'h0000_004B;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_pending0: ready=%b want 0", cfg_if.cfg_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_pending%0d: ready=%b want 0", k + 1, cfg_if.cfg_ready); end
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_copy: ready=%b want 0", cfg_if.cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL hs_after: ready=%b want 1", cfg_if.cfg_ready); end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    pixel(11'd10, 10'd300);
    checks++; if (char_code !== 8'h58) begin errors++; $display("FAIL hs_not_active: got %h want 58", char_code); end
    commit_frame();
    pixel(11'd10, 10'd300);
    checks++; if (char_code !== 8'h4B) begin errors++; $display("FAIL hs_second_commit: got %h want 4b", char_code); end
  endtask

  task automatic test_reset_pending();
    wr_hdr(2'd0, hdr_word(11'd200, 10'd100, 5'd2, 2'd1, 1'b1));
    @(negedge clk);
    cfg_if.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_if.cfg_commit = 1'b0;
    checks++; if (cfg_if.commit_busy !== 1'b1) begin errors++; $display("FAIL rp_busy: got %b want 1", cfg_if.commit_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (cfg_if.commit_busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1)
      begin errors++; $display("FAIL rp_async: busy=%b ready=%b want 0 1", cfg_if.commit_busy, cfg_if.cfg_ready); end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cfg_if.cfg_ready !== 1'b1 || out_valid !== 1'b0 || char_code !== 8'h20 || char_scale !== 2'd1)
      begin errors++; $display("FAIL rp_release: rdy=%b v=%b ch=%h sc=%0d want 1 0 20 1", cfg_if.cfg_ready, out_valid, char_code, char_scale); end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    pixel(11'd200, 10'd100);
    checks++; if (slot_hit !== 1'b0) begin errors++; $display("FAIL rp_nocopy: got hit=%b want 0", slot_hit); end
    commit_frame();
    pixel(11'd200, 10'd100);
    checks++; if (slot_hit !== 1'b0 || char_code !== 8'h20)
      begin errors++; $display("FAIL rp_shadow_cleared: hit=%b ch=%h want 0 20", slot_hit, char_code); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i <= 642; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 642) begin
        checks++;
        if (out_valid !== 1'b1 || out_x !== 11'(i - 2) || out_y !== 10'(((i - 2) * 7) % 1024))
          begin errors++; $display("FAIL stream_%0d: v=%b x=%0d y=%0d want 1 %0d %0d", i, out_valid, out_x, out_y, i - 2, ((i - 2) * 7) % 1024); end
      end else if (i == 642) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: v=%b want 0", out_valid); end
      end
      if (i < 640) begin
        pix_valid = 1'b1;
        curr_x    = 11'(i);
        curr_y    = 10'((i * 7) % 1024);
      end else begin
        pix_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_boundaries();
    test_handshake();
    test_reset_pending();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
